// File: rtl/cpu_phase_sequencer.sv
// cpu_phase_sequencer: multi-cycle phase sequencer owning pc and retired-instruction count.
// Ports: clk/reset (async active-high); stall holds the current phase; skip_mem bypasses SKIP_PHASE
// when leaving SKIP_PHASE-1; branch_taken/branch_target/halt are sampled when leaving the last phase.
// Outputs (all registered): phase_en/phase_start one-hot, phase_idx, pc, retire pulse, instr_count, halted.
module cpu_phase_sequencer #(
  parameter int                    NUM_PHASES = 5,
  parameter int                    SKIP_PHASE = 3,
  parameter int                    PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0,
  parameter int                    PC_STEP    = 4,
  parameter int                    ALIGN_BITS = 2,
  parameter int                    CNT_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic                          skip_mem,
  input  logic                          branch_taken,
  input  logic [PC_WIDTH-1:0]           branch_target,
  input  logic                          halt,
  output logic [NUM_PHASES-1:0]         phase_en,
  output logic [NUM_PHASES-1:0]         phase_start,
  output logic [$clog2(NUM_PHASES)-1:0] phase_idx,
  output logic [PC_WIDTH-1:0]           pc,
  output logic                          retire,
  output logic [CNT_WIDTH-1:0]          instr_count,
  output logic                          halted
);
  localparam int IW = $clog2(NUM_PHASES);
  if (NUM_PHASES < 3 || NUM_PHASES > 8) begin : g_bad_num_phases
    $error("NUM_PHASES must be in 3..8");
  end
  if (SKIP_PHASE < 1 || SKIP_PHASE > NUM_PHASES - 2) begin : g_bad_skip_phase
    $error("SKIP_PHASE must be in 1..NUM_PHASES-2");
  end
  if (ALIGN_BITS < 0 || ALIGN_BITS >= PC_WIDTH) begin : g_bad_align
    $error("ALIGN_BITS must be in 0..PC_WIDTH-1");
  end
  typedef enum logic [1:0] {WAIT, RUN, HALTED} state_t;
  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_PHASES-1:0] en_q, en_d, start_q, start_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  retire_q, retire_d, halted_q, last;
  assign last = idx_q == IW'(NUM_PHASES - 1);
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    retire_d = 1'b0;
    start_d  = '0;
    if (state_q == WAIT) begin
      state_d = RUN;
      idx_d   = '0;
      start_d = NUM_PHASES'(1);
    end else if (state_q == RUN && !stall) begin
      if (last) begin
        pc_d     = branch_taken ? (branch_target >> ALIGN_BITS) << ALIGN_BITS : pc_q + PC_WIDTH'(PC_STEP);
        cnt_d    = cnt_q + CNT_WIDTH'(1);
        retire_d = 1'b1;
        state_d  = halt ? HALTED : RUN;
        idx_d    = '0;
        start_d  = halt ? '0 : NUM_PHASES'(1);
      end else begin
        idx_d   = (idx_q == IW'(SKIP_PHASE - 1) && skip_mem) ? IW'(SKIP_PHASE + 1) : idx_q + IW'(1);
        start_d = NUM_PHASES'(1) << idx_d;
      end
    end
    en_d = (state_d == RUN) ? NUM_PHASES'(1) << idx_d : '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= WAIT;
      idx_q    <= '0;
      en_q     <= '0;
      start_q  <= '0;
      pc_q     <= RESET_PC;
      cnt_q    <= '0;
      retire_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      en_q     <= en_d;
      start_q  <= start_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      retire_q <= retire_d;
      halted_q <= state_d == HALTED;
    end
  end
  assign phase_en    = en_q;
  assign phase_start = start_q;
  assign phase_idx   = idx_q;
  assign pc          = pc_q;
  assign retire      = retire_q;
  assign instr_count = cnt_q;
  assign halted      = halted_q;
endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// tb_cpu_phase_sequencer: instruction-level reference model checking phase trace, pc and retire count.
module tb_cpu_phase_sequencer;
  localparam int NP = 5;
  localparam int SK = 3;
  logic clk = 0, reset = 1, stall = 0, skip_mem = 0, branch_taken = 0, halt = 0;
  logic [31:0] branch_target = '0;
  logic [NP-1:0] phase_en, phase_start;
  logic [2:0] phase_idx;
  logic [31:0] pc, instr_count;
  logic retire, halted;
  logic w_branch = 0;
  logic [7:0] w_target = '0;
  logic [NP-1:0] w_en, w_start;
  logic [2:0] w_idx;
  logic [7:0] w_pc;
  logic [3:0] w_cnt;
  logic w_retire, w_halted;
  int n_checks = 0, n_fail = 0;
  logic [31:0] exp_pc = '0, exp_cnt = '0;
  bit exp_ret = 0;

  cpu_phase_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .skip_mem(skip_mem), .branch_taken(branch_taken),
    .branch_target(branch_target), .halt(halt), .phase_en(phase_en), .phase_start(phase_start),
    .phase_idx(phase_idx), .pc(pc), .retire(retire), .instr_count(instr_count), .halted(halted)
  );
  cpu_phase_sequencer #(.PC_WIDTH(8), .CNT_WIDTH(4)) dut_w (
    .clk(clk), .reset(reset), .stall(1'b0), .skip_mem(1'b0), .branch_taken(w_branch),
    .branch_target(w_target), .halt(1'b0), .phase_en(w_en), .phase_start(w_start),
    .phase_idx(w_idx), .pc(w_pc), .retire(w_retire), .instr_count(w_cnt), .halted(w_halted)
  );

  always #5 clk = ~clk;

  task automatic run_instr(input bit do_skip, input bit br, input logic [31:0] tgt, input bit hlt,
                           input int fix_ph, input int fix_len, input int max_st);
    for (int p = 0; p < NP; p++) begin
      int ns;
      if (do_skip && p == SK) continue;
      ns = (p == fix_ph) ? fix_len : int'($urandom_range(max_st));
      for (int c = 0; c <= ns; c++) begin
        logic [NP-1:0] e_en, e_st;
        bit e_ret, adv;
        e_en  = NP'(1) << p;
        e_st  = (c == 0) ? e_en : '0;
        e_ret = (p == 0 && c == 0) ? exp_ret : 1'b0;
        n_checks++;
        if ({phase_en, phase_start, phase_idx, pc, retire, instr_count, halted} !==
            {e_en, e_st, 3'(p), exp_pc, e_ret, exp_cnt, 1'b0}) begin
          n_fail++;
          $display("FAIL run_instr p=%0d c=%0d en=%b/%b start=%b/%b idx=%0d/%0d pc=%h/%h retire=%b/%b cnt=%0d/%0d halted=%b/0",
                   p, c, phase_en, e_en, phase_start, e_st, phase_idx, p, pc, exp_pc, retire, e_ret,
                   instr_count, exp_cnt, halted);
        end
        adv           = (c == ns);
        stall         = !adv;
        skip_mem      = (p == SK - 1 && adv) ? do_skip : 1'($urandom);
        branch_taken  = (p == NP - 1 && adv) ? br : 1'($urandom);
        halt          = (p == NP - 1 && adv) ? hlt : 1'($urandom);
        branch_target = (p == NP - 1 && adv) ? tgt : $urandom;
        @(posedge clk); #1;
      end
    end
    if (do_skip) exp_ret = 1;
    exp_pc  = br ? (tgt & ~32'h3) : exp_pc + 32'd4;
    exp_cnt = exp_cnt + 1;
    exp_ret = 1;
  endtask

  task automatic test_reset;
    reset = 1;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({phase_en, phase_start, phase_idx, pc, retire, instr_count, halted} !== '0) begin
        n_fail++;
        $display("FAIL reset i=%0d en=%b start=%b idx=%0d pc=%h retire=%b cnt=%0d halted=%b required all zero",
                 i, phase_en, phase_start, phase_idx, pc, retire, instr_count, halted);
      end
      if (i == 1) reset = 0;
      else if (i == 0) begin @(posedge clk); #1; @(posedge clk); #1; end
    end
    exp_pc = 0; exp_cnt = 0; exp_ret = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_free_run;
    for (int i = 0; i < 3; i++) run_instr(0, 0, 0, 0, -1, 0, 0);
    n_checks++;
    if (pc !== 32'd12 || instr_count !== 32'd3) begin
      n_fail++;
      $display("FAIL free_run pc=%h cnt=%0d required 0000000c/3", pc, instr_count);
    end
  endtask

  task automatic test_stall;
    run_instr(0, 0, 0, 0, 3, 3, 0);
    run_instr(0, 0, 0, 0, 0, 2, 0);
  endtask

  task automatic test_skip;
    run_instr(1, 0, 0, 0, -1, 0, 0);
    run_instr(1, 0, 0, 0, -1, 0, 2);
  endtask

  task automatic test_branch;
    run_instr(0, 1, 32'h0000_0103, 0, -1, 0, 0);
    n_checks++;
    if (pc !== 32'h0000_0100) begin
      n_fail++;
      $display("FAIL branch pc=%h required 00000100", pc);
    end
    run_instr(0, 0, 0, 0, -1, 0, 1);
    n_checks++;
    if (pc !== 32'h0000_0104) begin
      n_fail++;
      $display("FAIL branch_ignored pc=%h required 00000104", pc);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++)
      run_instr(1'($urandom), 1'($urandom), $urandom, 0, -1, 0, 3);
  endtask

  task automatic test_halt;
    run_instr(0, 0, 0, 1, -1, 0, 2);
    for (int i = 0; i < 22; i++) begin
      n_checks++;
      if ({phase_en, phase_start, pc, retire, instr_count, halted} !==
          {{NP{1'b0}}, {NP{1'b0}}, exp_pc, i == 0, exp_cnt, 1'b1}) begin
        n_fail++;
        $display("FAIL halt i=%0d en=%b start=%b pc=%h/%h retire=%b/%b cnt=%0d/%0d halted=%b/1",
                 i, phase_en, phase_start, pc, exp_pc, retire, i == 0, instr_count, exp_cnt, halted);
      end
      stall = 1'($urandom); skip_mem = 1'($urandom); branch_taken = 1'($urandom);
      halt = 1'($urandom); branch_target = $urandom;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mid_reset;
    reset = 1;
    #1;
    @(posedge clk); #1;
    reset = 0; stall = 0; skip_mem = 0; branch_taken = 0; halt = 0;
    exp_pc = 0; exp_cnt = 0; exp_ret = 0;
    @(posedge clk); #1;
    run_instr(0, 0, 0, 0, -1, 0, 1);
    run_instr(0, 1, 32'h0000_0040, 0, -1, 0, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (phase_idx !== 3'd2 || phase_en !== 5'b00100) begin
      n_fail++;
      $display("FAIL mid_reset_setup idx=%0d en=%b required 2/00100", phase_idx, phase_en);
    end
    #2 reset = 1;
    #1;
    n_checks++;
    if ({phase_en, phase_start, phase_idx, pc, retire, instr_count, halted} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_async en=%b pc=%h retire=%b cnt=%0d required all zero", phase_en, pc, retire, instr_count);
    end
    @(posedge clk); #1;
    reset = 0;
    exp_pc = 0; exp_cnt = 0; exp_ret = 0;
    @(posedge clk); #1;
    run_instr(0, 0, 0, 0, -1, 0, 1);
  endtask

  task automatic test_wrap;
    int n;
    logic [7:0] e_pc;
    reset = 1;
    stall = 0; skip_mem = 0; branch_taken = 0; halt = 0;
    #1;
    @(posedge clk); #1;
    reset = 0; w_branch = 1; w_target = 8'hFC; n = 0;
    for (int cyc = 0; cyc < 200 && n < 16; cyc++) begin
      @(posedge clk); #1;
      if (w_retire) begin
        n++;
        e_pc = (n == 1) ? 8'hFC : 8'(8'hFC + 4 * (n - 1));
        w_branch = 0;
        n_checks++;
        if (w_pc !== e_pc || w_cnt !== 4'(n)) begin
          n_fail++;
          $display("FAIL wrap n=%0d pc=%h/%h cnt=%0d/%0d", n, w_pc, e_pc, w_cnt, 4'(n));
        end
      end
    end
    n_checks++;
    if (n != 16 || w_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL wrap_final retires=%0d cnt=%0d required 16/0", n, w_cnt);
    end
  endtask

  initial begin
    test_reset;
    test_free_run;
    test_stall;
    test_skip;
    test_branch;
    test_random;
    test_halt;
    test_mid_reset;
    test_wrap;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_phase_sequencer.md
Name: cpu_phase_sequencer

Overview:
- Parametrised multi-cycle phase sequencer for the single-issue RISC-V core. It is the successor to the fixed three-output (pc/instruct/mem) clock-phase state machine.
- Generates one-hot phase enables and phase-entry strobes, with stall hold, optional memory-phase skip, halt, and an integrated PC register.
- Sits between the top-level clock and the fetch/decode/execute/memory/writeback units. It owns the PC and the retired-instruction counter.

Parameters:
- NUM_PHASES, 5, number of phases per instruction (0 = fetch … NUM_PHASES-1 = writeback); legal range 3..8.
- SKIP_PHASE, 3, index of the skippable (memory) phase; legal range 1..NUM_PHASES-2.
- PC_WIDTH, 32, width of pc and branch_target.
- RESET_PC, 0, pc value loaded on reset.
- PC_STEP, 4, sequential pc increment.
- ALIGN_BITS, 2, number of low bits of branch_target forced to 0 on load.
- CNT_WIDTH, 32, width of instr_count.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold current phase this cycle.
- skip_mem  in  1  sampled when leaving phase SKIP_PHASE-1; high = bypass SKIP_PHASE.
- branch_taken  in  1  sampled when leaving last phase; selects branch_target for next pc.
- branch_target  in  PC_WIDTH  next pc when branch_taken.
- halt  in  1  sampled when leaving last phase; enter HALTED.
- phase_en  out  NUM_PHASES  one-hot, high for every cycle spent in a phase.
- phase_start  out  NUM_PHASES  one-hot, high only in the first cycle of a phase.
- phase_idx  out  $clog2(NUM_PHASES)  current phase index.
- pc  out  PC_WIDTH  address of the instruction in flight.
- retire  out  1  one-cycle pulse in the cycle after the last phase completes.
- instr_count  out  CNT_WIDTH  retired instructions, wraps modulo 2^CNT_WIDTH.
- halted  out  1  high while in HALTED.

Behaviour:
- States: WAIT (post-reset), RUN(phase k), HALTED. All outputs are registered.
- Reset (async, active-high), applied immediately:
  - state=WAIT, phase_en=0, phase_start=0, phase_idx=0.
  - pc=RESET_PC, retire=0, instr_count=0, halted=0.
- Reset asserted mid-instruction aborts the instruction: no retire, pc returns to RESET_PC.
- WAIT -> RUN(0) on the first rising edge after reset deasserts; phase_start[0]=1 in that cycle.
- RUN(k), stall=1: remain in k. phase_en[k] stays high, phase_start=0. No input other than stall is sampled.
- RUN(k), stall=0 (advancing cycle):
  - k = SKIP_PHASE-1 and skip_mem=1: next phase is SKIP_PHASE+1.
  - k < NUM_PHASES-1 otherwise: next phase is k+1.
  - k = NUM_PHASES-1: instruction completes, as follows:
    - pc <= branch_taken ? {branch_target[PC_WIDTH-1:ALIGN_BITS], ALIGN_BITS zeros} : pc+PC_STEP (truncated to PC_WIDTH, wraps).
    - retire=1 and instr_count+1 both take effect in the next cycle.
    - halt=0: next phase is 0. halt=1: next state is HALTED.
- skip_mem is ignored at every other phase. branch_taken and halt are ignored in every phase other than the last.
- phase_start[j]=1 exactly on the first cycle of a new phase j, including after a skip.
- Minimum instruction length: NUM_PHASES cycles, or NUM_PHASES-1 with skip.
- retire is coincident with phase_start[0] of the next instruction, or with the first HALTED cycle.
- HALTED:
  - phase_en=0, phase_start=0, halted=1.
  - pc and instr_count frozen; all inputs ignored.
  - Exit only via reset.
- Priority: reset > stall > (skip_mem | branch_taken | halt).
- No combinational paths from inputs to outputs.
- Elaboration error for out-of-range parameters.

Test Plan:
- Reset/free run: reset high 2 cycles, then low, all other inputs 0 -> pc=0 and phase_en=0 during reset. Then phase_en = 00001, 00010, 00100, 01000, 10000, 00001. retire=1 and pc=4 in the 6th cycle; after 3 instructions instr_count=3 and pc=12.
- Stall: stall=1 for 3 cycles while in phase 3 -> phase_en=01000 for 4 cycles, phase_start[3] only in the first. Instruction takes 8 cycles; pc increments once.
- Skip: skip_mem=1 during the advancing cycle of phase 2 -> phase_en sequence 00001, 00010, 00100, 10000. phase_start[4] fires directly after phase 2; retire after 4 cycles.
- Branch: branch_taken=1, branch_target=0x0000_0103 in the last cycle of phase 4 -> pc=0x0000_0100. branch_taken=1 in phase 2 has no effect (pc=prev+4).
- Halt and mid-op reset: halt=1 in phase 4 -> retire pulse, then halted=1, phase_en=0 for 20+ cycles, pc frozen. Reset pulse asserted mid-phase 2 -> phase_en=0 and pc=RESET_PC immediately, no retire.
- Wrap (PC_WIDTH=8, CNT_WIDTH=4): pc=0xFC retires -> pc=0x00. 16 retires -> instr_count=0.
